// File: rtl/cpu_types_pkg.sv
// Shared CPU types: sequencer state encoding, the data word type and the default lane-index type.
package cpu_types_pkg;

    localparam int WORD_BITS   = 32;
    localparam int VMS_THREADS = 4;
    localparam int VMS_LANE_W  = $clog2(VMS_THREADS);

    typedef logic [WORD_BITS-1:0]  word_t;
    typedef logic [VMS_LANE_W-1:0] lane_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        IFETCH,
        SDATA,
        VLANE,
        DONE
    } vms_state_t;

endpackage

// File: rtl/lane_find_next.sv
// Combinational next-set-bit finder: lowest set bit of mask strictly above cur.
// cur = -1 returns the lowest set bit overall.
module lane_find_next #(
    parameter int THREADS = 4
) (
    input  logic [THREADS-1:0]           mask,
    input  logic signed [$clog2(THREADS):0] cur,
    output logic [$clog2(THREADS)-1:0]   next,
    output logic                         none
);
    localparam int LW = $clog2(THREADS);

    always_comb begin
        next = '0;
        none = 1'b1;
        // Descending scan so the lowest qualifying lane is the last one assigned.
        for (int i = THREADS - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                next = i[LW-1:0];
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vector_mem_sequencer.sv
// Single-port memory sequencer: arbitrates fetch vs. scalar/vector data and serialises vector lanes.
// Optional macro VMS_COALESCE_EN: vector reads repeating the previous lane's address skip the bus.
module vector_mem_sequencer
    import cpu_types_pkg::*;
#(
    parameter int THREADS = VMS_THREADS,
    parameter int WORD_W  = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      iReq,
    input  logic [WORD_W-1:0]         iaddr,
    output logic                      iHit,
    output logic [WORD_W-1:0]         iload,
    input  logic                      dReadReq,
    input  logic                      dWriteReq,
    input  logic                      isVector,
    input  logic [THREADS-1:0]        mask,
    input  logic [WORD_W-1:0]         sdaddr,
    input  logic [WORD_W-1:0]         sdstore,
    output logic [WORD_W-1:0]         sdload,
    input  logic [THREADS*WORD_W-1:0] vdaddr,
    input  logic [THREADS*WORD_W-1:0] vdstore,
    output logic [THREADS*WORD_W-1:0] vdload,
    output logic                      dHit,
    input  logic                      dhalt,
    output logic                      memREN,
    output logic                      memWEN,
    output logic [WORD_W-1:0]         memaddr,
    output logic [WORD_W-1:0]         memstore,
    input  logic [WORD_W-1:0]         memload,
    input  logic                      memWait
);
    localparam int LW = $clog2(THREADS);

    vms_state_t          state_reg;
    logic [LW-1:0]       lane_reg;
    logic [WORD_W-1:0]   buf_reg    [THREADS];
    logic [WORD_W-1:0]   lane_addr  [THREADS];
    logic [WORD_W-1:0]   lane_store [THREADS];

    logic signed [LW:0]  search_cur;
    logic [LW-1:0]       next_lane;
    logic                next_none;
    logic                data_req;
    logic                is_write;
    logic                coalesce;
    logic                lane_done;

    // A simultaneous read and write request is served as a write.
    assign data_req = dReadReq | dWriteReq;
    assign is_write = dWriteReq;

    generate
        for (genvar gi = 0; gi < THREADS; gi++) begin : g_lane
            assign lane_addr[gi]                   = vdaddr[gi*WORD_W +: WORD_W];
            assign lane_store[gi]                  = vdstore[gi*WORD_W +: WORD_W];
            assign vdload[gi*WORD_W +: WORD_W]     = buf_reg[gi];
        end
    endgenerate

    // Outside VLANE the finder searches from -1, giving the first active lane.
    assign search_cur = (state_reg == VLANE) ? $signed({1'b0, lane_reg}) : '1;

    lane_find_next #(
        .THREADS (THREADS)
    ) u_find (
        .mask (mask),
        .cur  (search_cur),
        .next (next_lane),
        .none (next_none)
    );

`ifdef VMS_COALESCE_EN
    logic [WORD_W-1:0] last_addr_reg;
    logic [LW-1:0]     last_lane_reg;
    logic              last_valid_reg;

    assign coalesce = (state_reg == VLANE) && !is_write && last_valid_reg &&
                      (lane_addr[lane_reg] == last_addr_reg);
`else
    assign coalesce = 1'b0;
`endif

    assign lane_done = (state_reg == VLANE) && (coalesce || !memWait);

    always_comb begin
        memREN   = 1'b0;
        memWEN   = 1'b0;
        memaddr  = '0;
        memstore = '0;
        iHit     = 1'b0;
        iload    = '0;
        dHit     = 1'b0;
        sdload   = '0;
        case (state_reg)
            IFETCH: begin
                memREN  = 1'b1;
                memaddr = iaddr;
                if (!memWait) begin
                    iHit  = 1'b1;
                    iload = memload;
                end
            end
            SDATA: begin
                memaddr  = sdaddr;
                memREN   = !is_write;
                memWEN   = is_write;
                memstore = is_write ? sdstore : '0;
                if (!memWait) begin
                    dHit   = 1'b1;
                    sdload = memload;
                end
            end
            VLANE: begin
                memaddr  = lane_addr[lane_reg];
                memREN   = !is_write && !coalesce;
                memWEN   = is_write;
                memstore = is_write ? lane_store[lane_reg] : '0;
            end
            DONE: begin
                dHit = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            lane_reg  <= '0;
            for (int i = 0; i < THREADS; i++) buf_reg[i] <= '0;
`ifdef VMS_COALESCE_EN
            last_addr_reg  <= '0;
            last_lane_reg  <= '0;
            last_valid_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (data_req) begin
                        if (!isVector) begin
                            state_reg <= SDATA;
                        end else begin
                            // Clearing up front leaves inactive lanes at zero.
                            for (int i = 0; i < THREADS; i++) buf_reg[i] <= '0;
`ifdef VMS_COALESCE_EN
                            last_valid_reg <= 1'b0;
`endif
                            if (next_none) begin
                                state_reg <= DONE;
                            end else begin
                                lane_reg  <= next_lane;
                                state_reg <= VLANE;
                            end
                        end
                    end else if (iReq && !dhalt) begin
                        state_reg <= IFETCH;
                    end
                end
                IFETCH: if (!memWait) state_reg <= IDLE;
                SDATA:  if (!memWait) state_reg <= IDLE;
                VLANE: begin
                    if (lane_done) begin
                        if (!is_write) begin
`ifdef VMS_COALESCE_EN
                            buf_reg[lane_reg] <= coalesce ? buf_reg[last_lane_reg] : memload;
`else
                            buf_reg[lane_reg] <= memload;
`endif
                        end
`ifdef VMS_COALESCE_EN
                        last_addr_reg  <= lane_addr[lane_reg];
                        last_lane_reg  <= lane_reg;
                        last_valid_reg <= 1'b1;
`endif
                        if (next_none) begin
                            state_reg <= DONE;
                        end else begin
                            lane_reg <= next_lane;
                        end
                    end
                end
                DONE: begin
                    lane_reg  <= '0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench for vector_mem_sequencer: expected hits and bus accesses are queued at
// stimulus time and checked by a negedge monitor. Define VMS_COALESCE_EN to add the coalesce case.
module tb_vector_mem_sequencer;

    localparam int THREADS = 4;
    localparam int WORD_W  = 32;

    logic                      CLK = 1'b0;
    logic                      RST = 1'b1;
    logic                      iReq = 1'b0;
    logic [WORD_W-1:0]         iaddr = '0;
    logic                      iHit;
    logic [WORD_W-1:0]         iload;
    logic                      dReadReq = 1'b0;
    logic                      dWriteReq = 1'b0;
    logic                      isVector = 1'b0;
    logic [THREADS-1:0]        mask = '0;
    logic [WORD_W-1:0]         sdaddr = '0;
    logic [WORD_W-1:0]         sdstore = '0;
    logic [WORD_W-1:0]         sdload;
    logic [THREADS*WORD_W-1:0] vdaddr = '0;
    logic [THREADS*WORD_W-1:0] vdstore = '0;
    logic [THREADS*WORD_W-1:0] vdload;
    logic                      dHit;
    logic                      dhalt = 1'b0;
    logic                      memREN;
    logic                      memWEN;
    logic [WORD_W-1:0]         memaddr;
    logic [WORD_W-1:0]         memstore;
    logic [WORD_W-1:0]         memload;
    logic                      memWait = 1'b0;

    logic [WORD_W-1:0]         mem_off = 32'h1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int           kind;      // 0 fetch, 1 scalar data, 2 vector
        logic [127:0] data;
        bit           chk_data;
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    logic [64:0]  bus_q[$];

    vector_mem_sequencer #(.THREADS(THREADS), .WORD_W(WORD_W)) dut (
        .CLK(CLK), .RST(RST),
        .iReq(iReq), .iaddr(iaddr), .iHit(iHit), .iload(iload),
        .dReadReq(dReadReq), .dWriteReq(dWriteReq), .isVector(isVector), .mask(mask),
        .sdaddr(sdaddr), .sdstore(sdstore), .sdload(sdload),
        .vdaddr(vdaddr), .vdstore(vdstore), .vdload(vdload), .dHit(dHit),
        .dhalt(dhalt),
        .memREN(memREN), .memWEN(memWEN), .memaddr(memaddr), .memstore(memstore),
        .memload(memload), .memWait(memWait)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Memory model: read data is the address plus a per-test offset.
    assign memload = memREN ? (memaddr + mem_off) : '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input logic [127:0] data, input bit chk, input int lat);
        exp_t e;
        e.kind = kind; e.data = data; e.chk_data = chk; e.cyc = cyc + lat - 1;
        exp_q.push_back(e);
    endtask

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        bus_q.push_back({we, addr, wd});
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_hit(input int max);
        int n = 0;
        bit got = 0;
        while (!got && n < max) begin
            @(negedge CLK);
            if (iHit || dHit) got = 1;
            n++;
        end
        if (!got) check("hit_timeout", 128'(0), 128'(1));
    endtask

    task automatic drop_all();
        iReq = 0; dReadReq = 0; dWriteReq = 0; isVector = 0; mask = '0;
    endtask

    // Monitor: one line per completed transaction.
    always @(negedge CLK) begin
        if (!RST) begin
            if (iHit || dHit) begin
                if (exp_q.size() == 0) begin
                    check("hit_unexpected", 128'({iHit, dHit}), 128'(0));
                end else begin
                    exp_t e;
                    int k;
                    logic [127:0] d;
                    e = exp_q.pop_front();
                    k = iHit ? 0 : (isVector ? 2 : 1);
                    d = (k == 0) ? 128'(iload) : (k == 1) ? 128'(sdload) : vdload;
                    $display("hit kind=%0d data=%0h cycle=%0d", k, d, cyc);
                    check("hit_kind", 128'(k), 128'(e.kind));
                    check("hit_cycle", 128'(cyc), 128'(e.cyc));
                    if (e.chk_data) check("hit_data", d, e.data);
                end
            end
            if ((memREN || memWEN) && !memWait) begin
                logic [64:0] got;
                got = {memWEN, memaddr, memWEN ? memstore : 32'h0};
                if (bus_q.size() == 0) check("bus_unexpected", 128'(got), 128'(0));
                else check("bus_access", 128'(got), 128'(bus_q.pop_front()));
            end
            if (!iHit) check("iload_zero", 128'(iload), 128'(0));
        end
    end

    initial begin
        // Reset state
        #1;
        check("rst_outs", 128'({iHit, dHit, memREN, memWEN}), 128'(0));
        check("rst_vdload", vdload, 128'(0));
        repeat (3) @(posedge CLK);
        #1 RST = 0;
        check("post_rst_outs", 128'({iHit, dHit, memREN, memWEN, memaddr, iload, sdload}), 128'(0));
        check("post_rst_vdload", vdload, 128'(0));
        next_cycle();

        // Fetch, memload 0xDEADBEEF
        mem_off = 32'hDEADBEEF - 32'h40;
        iReq = 1; iaddr = 32'h40;
        push_exp(0, 128'(32'hDEADBEEF), 1, 2);
        push_bus(0, 32'h40, 0);
        wait_hit(10);
        next_cycle(); drop_all();
        mem_off = 32'h1;
        next_cycle();

        // Fetch and scalar read together: data first, fetch 2 cycles after
        iReq = 1; iaddr = 32'h80; dReadReq = 1; sdaddr = 32'h100;
        push_exp(1, 128'(32'h101), 1, 2);
        push_exp(0, 128'(32'h81), 1, 4);
        push_bus(0, 32'h100, 0);
        push_bus(0, 32'h80, 0);
        wait_hit(10);
        next_cycle(); dReadReq = 0;
        wait_hit(10);
        next_cycle(); drop_all();
        next_cycle();

        // Vector read mask 1011
        dReadReq = 1; isVector = 1; mask = 4'b1011;
        vdaddr = {32'h30, 32'h20, 32'h10, 32'h00};
        push_bus(0, 32'h00, 0); push_bus(0, 32'h10, 0); push_bus(0, 32'h30, 0);
        push_exp(2, {32'h31, 32'h0, 32'h11, 32'h01}, 1, 5);
        wait_hit(20);
        next_cycle(); drop_all();
        next_cycle();

        // Vector write mask 0: no access, buffer cleared
        dWriteReq = 1; isVector = 1; mask = 4'b0000;
        push_exp(2, 128'(0), 1, 2);
        wait_hit(10);
        next_cycle(); drop_all();
        next_cycle();

        // Vector write mask 0110
        dWriteReq = 1; isVector = 1; mask = 4'b0110;
        vdaddr  = {32'h70, 32'h60, 32'h50, 32'h40};
        vdstore = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        push_bus(1, 32'h50, 32'hD1); push_bus(1, 32'h60, 32'hD2);
        push_exp(2, 128'(0), 1, 4);
        wait_hit(20);
        next_cycle(); drop_all();
        next_cycle();

        // Only the top lane active
        dReadReq = 1; isVector = 1; mask = 4'b1000;
        vdaddr = {32'h3C, 32'h2C, 32'h1C, 32'h0C};
        push_bus(0, 32'h3C, 0);
        push_exp(2, {32'h3D, 32'h0, 32'h0, 32'h0}, 1, 3);
        wait_hit(10);
        next_cycle(); drop_all();
        next_cycle();

        // memWait high for 3 cycles on lane 1
        dReadReq = 1; isVector = 1; mask = 4'b1011;
        vdaddr = {32'h30, 32'h20, 32'h10, 32'h00};
        push_bus(0, 32'h00, 0); push_bus(0, 32'h10, 0); push_bus(0, 32'h30, 0);
        push_exp(2, {32'h31, 32'h0, 32'h11, 32'h01}, 1, 8);
        next_cycle();
        next_cycle();
        memWait = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("wait_addr", 128'({memREN, memaddr}), 128'({1'b1, 32'h10}));
            next_cycle();
        end
        memWait = 0;
        wait_hit(20);
        next_cycle(); drop_all();
        next_cycle();

        // dhalt blocks fetch entry
        dhalt = 1; iReq = 1; iaddr = 32'h44;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("dhalt_noren", 128'(memREN), 128'(0));
            next_cycle();
        end
        dhalt = 0;
        push_exp(0, 128'(32'h45), 1, 2);
        push_bus(0, 32'h44, 0);
        wait_hit(10);
        next_cycle(); drop_all();
        next_cycle();

        // Scalar write
        dWriteReq = 1; sdaddr = 32'h200; sdstore = 32'hCAFE0001;
        push_bus(1, 32'h200, 32'hCAFE0001);
        push_exp(1, 128'(0), 0, 2);
        wait_hit(10);
        next_cycle(); drop_all();
        next_cycle();

        // Reset during lane 2 of a vector read
        dReadReq = 1; isVector = 1; mask = 4'b0111;
        vdaddr = {32'h70, 32'h60, 32'h50, 32'h40};
        push_bus(0, 32'h40, 0); push_bus(0, 32'h50, 0);
        next_cycle(); next_cycle(); next_cycle();
        check("pre_rst_lane2", 128'({memREN, memaddr}), 128'({1'b1, 32'h60}));
        #2 RST = 1;
        drop_all();
        #1;
        check("rst_ren_drop", 128'({memREN, memWEN, dHit}), 128'(0));
        @(posedge CLK);
        #1 RST = 0;
        check("rst_vdload", vdload, 128'(0));
        next_cycle();
        check("rst_idle", 128'({memREN, memWEN, dHit, iHit}), 128'(0));
        next_cycle();

`ifdef VMS_COALESCE_EN
        // All lanes at one address: a single bus read
        dReadReq = 1; isVector = 1; mask = 4'b1111;
        vdaddr = {4{32'h80}};
        push_bus(0, 32'h80, 0);
        push_exp(2, {4{32'h81}}, 1, 6);
        wait_hit(20);
        next_cycle(); drop_all();
        next_cycle();
`endif

        repeat (3) next_cycle();
        check("exp_q_empty", 128'(exp_q.size()), 128'(0));
        check("bus_q_empty", 128'(bus_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
- Single-port memory controller between the datapath's load/store unit and the unified memory bus.
- Arbitrates instruction fetch against scalar and vector data requests.
- Serialises a vector load/store into one memory access per active lane, using the SIMT mask, and gathers per-lane read data.
- Returns one hit pulse per completed request.

Parameters:
- THREADS, 4, number of vector lanes; power of two, 2 to 16.
- WORD_W, 32, data and address width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- iReq  in  1  instruction fetch request.
- iaddr  in  WORD_W  fetch address.
- iHit  out  1  fetch complete this cycle.
- iload  out  WORD_W  fetched word; valid while iHit=1.
- dReadReq  in  1  data read request.
- dWriteReq  in  1  data write request.
- isVector  in  1  data request is vector.
- mask  in  THREADS  active lanes; bit i = lane i.
- sdaddr  in  WORD_W  scalar data address.
- sdstore  in  WORD_W  scalar store data.
- sdload  out  WORD_W  scalar load data; valid while dHit=1.
- vdaddr  in  THREADS*WORD_W  lane addresses; lane i = bits [i*WORD_W +: WORD_W].
- vdstore  in  THREADS*WORD_W  lane store data.
- vdload  out  THREADS*WORD_W  gathered lane load data, registered.
- dHit  out  1  data request complete.
- dhalt  in  1  stop issuing new fetches.
- memREN  out  1  memory read enable.
- memWEN  out  1  memory write enable.
- memaddr  out  WORD_W  memory address.
- memstore  out  WORD_W  memory write data.
- memload  in  WORD_W  memory read data.
- memWait  in  1  memory busy; an access completes in a cycle where it is enabled and memWait=0.

Behaviour:
- States: IDLE, IFETCH, SDATA, VLANE, DONE. Reset puts state in IDLE, lane counter at 0, and the vdload buffer at 0. All outputs are 0 during and directly after reset.
- Request handshake: the requester holds the request and its operands stable until its Hit pulse. It may drop or change them on the cycle after the pulse. Hits are single-cycle.
- dReadReq and dWriteReq asserted together: treat as a write. Verification flags it as a protocol error.
- IDLE, arbitration evaluated every cycle, data has strict priority:
  - Data request with isVector=0 -> SDATA.
  - Data request with isVector=1 and mask non-zero -> VLANE, lane counter set to the lowest set mask bit.
  - Data request with isVector=1 and mask=0 -> DONE. No memory access is made.
  - Otherwise iReq=1 and dhalt=0 -> IFETCH.
  - IDLE drives memREN=memWEN=0.
- IFETCH:
  - memREN=1, memaddr=iaddr.
  - On memWait=0: iHit=1, iload=memload (combinational pass-through), then -> IDLE.
- SDATA:
  - memaddr=sdaddr.
  - Read: memREN=1. Write: memWEN=1, memstore=sdstore.
  - On memWait=0: dHit=1, sdload=memload, then -> IDLE.
- VLANE:
  - memaddr and memstore come from the current lane.
  - On memWait=0 for a read, buffer[lane] <= memload.
  - Lane counter then advances to the next set mask bit above the current lane.
  - If no higher set bit exists, or the current lane is THREADS-1 (no wrap-around), -> DONE.
  - Inactive lanes are never accessed and their buffer entries are written 0.
  - mask is sampled every cycle; requester holds it stable.
- DONE: dHit=1 for one cycle, vdload valid from the buffer, then -> IDLE.
- Minimum latencies with memWait=0:
  - Scalar access or fetch: request accepted in IDLE, Hit on the next cycle. 2 cycles per request.
  - Vector with k active lanes: k+2 cycles.
- dhalt=1: blocks new IFETCH entry only. An in-flight fetch or data access completes normally.
- RST asserted mid-access: aborts immediately. Enables drop asynchronously and no Hit is generated.
- sdload and iload are 0 whenever their Hit is low.

Optional Feature:
- Macro: VMS_COALESCE_EN.
- Defined: in VLANE, for a vector read where the current lane's address equals the address of the most recently accessed lane of the same request:
  - memREN stays 0 that cycle.
  - buffer[lane] is copied from that lane's buffered data.
  - Cost is 1 cycle with no bus access.
  - Writes are never coalesced.
- Not defined: every active lane issues its own memory access.

Decomposition:
- Shared package cpu_types_pkg:
  - vms_state_t enum.
  - word_t, already present.
  - THREADS-dependent lane index typedef.
- Sub-module lane_find_next: combinational next-set-bit finder. Inputs are mask and current lane; outputs are the next lane and a none flag. It is reused for the initial-lane search with current lane = -1.

Test Plan:
- Scalar fetch, iaddr=0x40, memload=0xDEADBEEF, memWait=0 -> iHit on cycle 2 with iload=0xDEADBEEF, memREN high for 1 cycle.
- iReq and dReadReq together, sdaddr=0x100 -> SDATA served first with dHit. The fetch of iaddr then completes with iHit 2 cycles later.
- Vector read, mask=4'b1011, vdaddr={0x30,0x20,0x10,0x00} (lanes 3..0), memory returns addr+1 -> exactly 3 accesses at 0x00, 0x10, 0x30. dHit on cycle 5; vdload = {0x31,0,0x11,0x01}.
- Vector write, mask=0 -> no memWEN, dHit on cycle 2.
- memWait held high for 3 cycles during lane 1 -> memaddr stable throughout, lane advances only after memWait falls, dHit delayed by 3 cycles.
- RST pulse during VLANE lane 2 -> memREN drops same cycle, no dHit. After release: IDLE, vdload=0.
- (VMS_COALESCE_EN) mask=4'b1111 with all lanes at 0x80 -> 1 bus read, all lanes equal memload, dHit on cycle 6.
